// File: rtl/lsu_arbiter.sv
// lsu_arbiter
//
// This block shares one load/store unit between NREQ requesters. Index 0 is
// the core and index 1 is debug/DMA. Each access takes one of two paths:
//   legal   : grant (IDLE) -> LSU cycle (ACCESS) -> response (RESP)
//   illegal : grant (IDLE) -> response with err_o=1 (RESP), and the LSU is
//             never touched
// When several requesters ask at once, round-robin arbitration picks the
// winner. After reset the priority pointer favours requester 0.
//
// Ports
//   clk_i          : clock; all state changes on its rising edge
//   rst_ni         : synchronous reset, ACTIVE HIGH (1 = reset) despite the name
//   req_i/we_i     : per-requester request and store(1)/load(0)
//   addr_i/wdata_i : per-requester byte address and store data
//   mem_op_i       : per-requester size code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   gnt_o          : one-hot grant pulse (IDLE only)
//   rvalid_o       : one-hot response pulse (RESP only)
//   rdata_o/err_o  : response data/error; held until the next response
//   lsu_*_o        : LSU request, active only in ACCESS
//   lsu_ld_data_i  : combinational LSU load data, captured at the end of ACCESS
module lsu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       we_i,
  input  logic [NREQ-1:0][31:0] addr_i,
  input  logic [NREQ-1:0][31:0] wdata_i,
  input  logic [NREQ-1:0][2:0]  mem_op_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic [31:0]           lsu_addr_o,
  output logic [31:0]           lsu_st_data_o,
  output logic                  lsu_st_en_o,
  output logic [2:0]            lsu_mem_op_o,
  input  logic [31:0]           lsu_ld_data_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Arbitration and request latches
  logic [IW-1:0] prio_reg;     // requester with the highest priority this round
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          win_we;
  logic [31:0]   win_addr;
  logic [31:0]   win_wdata;
  logic [2:0]    win_op;
  logic          win_illegal;
  logic          grant_take;   // a grant happens this cycle (before reset gating)

  logic [IW-1:0] idx_reg;
  logic          we_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [2:0]    op_reg;
  logic [31:0]   rdata_reg;
  logic          err_reg;

  // Decode an access that the memory map or the alignment rules forbid.
  // The 0x500 page is the switch input region and is read-only. The
  // 0x600-0x7FF range is unmapped, and so is everything from 0x800 upwards.
  function automatic logic access_illegal(input logic        we,
                                          input logic [31:0] addr,
                                          input logic [2:0]  op);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_B, OP_BU: bad = 1'b0;
      OP_H, OP_HU: bad = addr[0];
      OP_W:        bad = |addr[1:0];
      default:     bad = 1'b1;
    endcase
    if (|addr[31:11])                bad = 1'b1;
    if (addr[10:9] == 2'b11)         bad = 1'b1;
    if (we && addr[10:8] == 3'b101)  bad = 1'b1;
    return bad;
  endfunction

  // Round-robin search that starts at prio_reg. The first requesting index
  // in rotated order wins.
  always_comb begin
    int cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(prio_reg) + k) % NREQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  assign win_we      = we_i[win_idx];
  assign win_addr    = addr_i[win_idx];
  assign win_wdata   = wdata_i[win_idx];
  assign win_op      = mem_op_i[win_idx];
  assign win_illegal = access_illegal(win_we, win_addr, win_op);
  assign grant_take  = (state_reg == IDLE) && win_found;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = win_illegal ? RESP : ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, priority pointer and response registers
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      prio_reg  <= '0;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      op_reg    <= OP_W;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (grant_take) begin
        idx_reg   <= win_idx;
        we_reg    <= win_we;
        addr_reg  <= win_addr;
        wdata_reg <= win_wdata;
        op_reg    <= win_op;
        // After a win, the next index in rotation gets top priority.
        prio_reg  <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        // An illegal access goes straight to RESP, so its response is
        // loaded here. Both response registers then change exactly on
        // entry to RESP.
        if (win_illegal) begin
          rdata_reg <= '0;
          err_reg   <= 1'b1;
        end
      end
      if (state_reg == ACCESS) begin
        rdata_reg <= we_reg ? 32'h0 : lsu_ld_data_i;
        err_reg   <= 1'b0;
      end
    end
  end

  // FSM: outputs. Reset is a synchronous input that still takes effect in
  // the cycle it is asserted. It masks every pulse, so an access caught
  // mid-flight never writes memory and never responds.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign gnt_o[gi]    = !rst_ni && grant_take && (win_idx == IW'(gi));
      assign rvalid_o[gi] = !rst_ni && (state_reg == RESP) && (idx_reg == IW'(gi));
    end
  endgenerate

  always_comb begin
    lsu_addr_o    = 32'h0;
    lsu_st_data_o = 32'h0;
    lsu_st_en_o   = 1'b0;
    lsu_mem_op_o  = OP_W;
    if (!rst_ni && state_reg == ACCESS) begin
      lsu_addr_o    = addr_reg;
      lsu_st_data_o = wdata_reg;
      lsu_st_en_o   = we_reg;
      lsu_mem_op_o  = op_reg;
    end
  end

  assign rdata_o = rst_ni ? 32'h0 : rdata_reg;
  assign err_o   = rst_ni ? 1'b0  : err_reg;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter. The DUT is driven with directed
// transactions. A transaction-level model works out, every cycle, when
// grants, LSU accesses and responses must occur and with what values. It
// follows the timing rules: grant at N, LSU at N+1, response at N+2 (N+1
// when illegal). Hand-computed literals in the directed tasks pin the model.
module tb_lsu_arbiter;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req, we;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][2:0]  op;
  logic [1:0]       gnt, rvalid;
  logic [31:0]      rdata, lsu_addr, lsu_st_data, lsu_ld;
  logic             err, lsu_st_en;
  logic [2:0]       lsu_mem_op;

  always #5 clk = ~clk;

  lsu_arbiter #(.NREQ(2)) dut (
    .clk_i(clk), .rst_ni(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .mem_op_i(op), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .lsu_addr_o(lsu_addr),
    .lsu_st_data_o(lsu_st_data), .lsu_st_en_o(lsu_st_en),
    .lsu_mem_op_o(lsu_mem_op), .lsu_ld_data_i(lsu_ld)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Memory-map legality, written directly from the address ranges.
  function automatic bit legal_ok(input bit w, input logic [31:0] a, input logic [2:0] o);
    if (o == 3'd3 || o == 3'd6 || o == 3'd7) return 1'b0;
    if ((o == 3'd1 || o == 3'd5) && a[0]) return 1'b0;
    if (o == 3'd2 && (a % 4) != 0) return 1'b0;
    if (a >= 32'h800) return 1'b0;
    if (a >= 32'h600) return 1'b0;
    if (w && a >= 32'h500 && a < 32'h600) return 1'b0;
    return 1'b1;
  endfunction

  // Transaction-level model: the scheduled cycles of the access in flight.
  int          m_free   = 0;
  int          m_lsu_c  = -1;
  int          m_resp_c = -1;
  int          m_last   = 1;
  int          t_idx    = 0;
  bit          t_we, t_legal;
  logic [31:0] t_addr, t_wdata;
  logic [2:0]  t_op;
  logic [31:0] m_ld    = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_err   = 1'b0;

  always @(negedge clk) begin : model
    logic [1:0]  e_gnt, e_rv;
    logic        e_st;
    logic [31:0] e_addr, e_data;
    logic [2:0]  e_op;
    int          c, w;
    c = cyc;
    e_gnt = 2'b00; e_rv = 2'b00; e_st = 1'b0;
    e_addr = 32'h0; e_data = 32'h0; e_op = 3'b010;
    if (rst) begin
      m_lsu_c = -1; m_resp_c = -1; m_free = c + 1; m_last = 1;
      m_rdata = 32'h0; m_err = 1'b0;
    end else begin
      if (c == m_lsu_c) begin
        e_st = t_we; e_addr = t_addr; e_data = t_wdata; e_op = t_op;
        m_ld = lsu_ld;
      end
      if (c == m_resp_c) begin
        e_rv[t_idx] = 1'b1;
        m_rdata = (t_legal && !t_we) ? m_ld : 32'h0;
        m_err   = !t_legal;
      end
      if (c >= m_free && req != 2'b00) begin
        if (req == 2'b11) w = (m_last == 0) ? 1 : 0;
        else              w = req[1] ? 1 : 0;
        e_gnt[w] = 1'b1;
        t_idx = w; t_we = we[w]; t_addr = addr[w]; t_wdata = wdata[w]; t_op = op[w];
        t_legal = legal_ok(t_we, t_addr, t_op);
        if (t_legal) begin
          m_lsu_c = c + 1; m_resp_c = c + 2; m_free = c + 3;
        end else begin
          m_resp_c = c + 1; m_free = c + 2;
        end
        m_last = w;
      end
    end
    chk("gnt", gnt, e_gnt);
    chk("rvalid", rvalid, e_rv);
    chk("rdata", rdata, m_rdata);
    chk("err", err, m_err);
    chk("lsu_st_en", lsu_st_en, e_st);
    chk("lsu_addr", lsu_addr, e_addr);
    chk("lsu_st_data", lsu_st_data, e_data);
    chk("lsu_mem_op", lsu_mem_op, e_op);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        g = gnt;
        break;
      end
    end
    if (g == 2'b00) begin
      checks++; errors++;
      $display("FAIL gnt_timeout cycle=%0d got=none expected=grant", cyc);
    end
  endtask

  // One single-requester transaction, with literal expectations.
  task automatic txn(input int idx, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] o,
                     input logic [31:0] ld, input bit legal,
                     input logic [31:0] exp_rdata);
    logic [1:0] g;
    we[idx] = w; addr[idx] = a; wdata[idx] = wd; op[idx] = o; lsu_ld = ld;
    req[idx] = 1'b1;
    wait_gnt(g);
    chk("txn_gnt", g, 32'(1 << idx));
    step();
    req[idx] = 1'b0;
    if (legal) begin
      @(negedge clk);
      chk("txn_st_en", lsu_st_en, w);
      chk("txn_lsu_addr", lsu_addr, a);
      chk("txn_no_early_rvalid", rvalid, 0);
      step();
    end
    @(negedge clk);
    chk("txn_rvalid", rvalid, 32'(1 << idx));
    chk("txn_err", err, !legal);
    chk("txn_rdata", rdata, exp_rdata);
    step();
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] gseq [4];
    int         gcyc [4];
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    rst = 1'b1; req = 2'b11; we = 2'b00; addr = '0; wdata = '0;
    op = {3'b010, 3'b010}; lsu_ld = 32'h0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_mem_op", lsu_mem_op, 3'b010);
    step();
    rst = 1'b0; req = 2'b00;

    // Store then load word at 0x10
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b1, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    // Illegal accesses and legal boundary cases
    txn(1, 1'b0, 32'h3,   32'h0,    3'b001, 32'h55, 1'b0, 32'h0);
    txn(1, 1'b1, 32'h500, 32'hCAFE, 3'b010, 32'h0,  1'b0, 32'h0);
    txn(0, 1'b0, 32'h500, 32'h0,    3'b010, 32'hA5, 1'b1, 32'hA5);
    txn(1, 1'b0, 32'h602, 32'h0,    3'b101, 32'h77, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h800, 32'h0,    3'b000, 32'h66, 1'b0, 32'h0);
    txn(1, 1'b0, 32'h4,   32'h0,    3'b011, 32'h44, 1'b0, 32'h0);
    txn(0, 1'b1, 32'h102, 32'hBEEF, 3'b001, 32'h0,  1'b1, 32'h0);
    txn(1, 1'b0, 32'h1,   32'h0,    3'b100, 32'h80, 1'b1, 32'h80);

    // Both requesters held high: alternate grants, one every 3 cycles
    we = 2'b00; addr[0] = 32'h20; addr[1] = 32'h24; op = {3'b010, 3'b010};
    lsu_ld = 32'h11; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g);
      gseq[i] = g; gcyc[i] = cyc;
      step();
    end
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", gseq[i], exp_seq[i]);
      if (i > 0) chk("rr_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    repeat (3) step();

    // Reset during ACCESS of a store aborts it; pointer returns to requester 0
    we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h12345678; op[0] = 3'b010;
    req = 2'b01;
    wait_gnt(g);
    chk("abort_gnt", g, 1);
    step();
    req = 2'b00; rst = 1'b1;
    @(negedge clk);
    chk("abort_st_en", lsu_st_en, 0);
    chk("abort_rvalid", rvalid, 0);
    step();
    @(negedge clk);
    chk("abort_rvalid2", rvalid, 0);
    step();
    rst = 1'b0; we = 2'b00; addr[0] = 32'h20; addr[1] = 32'h24; req = 2'b11;
    @(negedge clk);
    chk("post_rst_gnt", gnt, 1);
    step();
    req = 2'b00;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (index 0 = core, 1 = debug/DMA); only NREQ=2 is required.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_ni  in  1  reset, synchronous and active-high (1 = reset).
REQ-004 SHALL have port req_i  in  2  per-requester access request, held until gnt.
REQ-005 SHALL have port we_i  in  2  per-requester store (1) / load (0).
REQ-006 SHALL have port addr_i  in  2x32  per-requester byte address.
REQ-007 SHALL have port wdata_i  in  2x32  per-requester store data.
REQ-008 SHALL have port mem_op_i  in  2x3  per-requester size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port gnt_o  out  2  one-hot grant pulse, 1 cycle.
REQ-010 SHALL have port rvalid_o  out  2  one-hot response pulse, 1 cycle.
REQ-011 SHALL have port rdata_o  out  32  response load data (0 for stores and errors).
REQ-012 SHALL have port err_o  out  1  response error flag, valid with rvalid_o.
REQ-013 SHALL have port lsu_addr_o  out  32  LSU address.
REQ-014 SHALL have port lsu_st_data_o  out  32  LSU store data.
REQ-015 SHALL have port lsu_st_en_o  out  1  LSU store enable.
REQ-016 SHALL have port lsu_mem_op_o  out  3  LSU size/sign code.
REQ-017 SHALL have port lsu_ld_data_i  in  32  LSU combinational load data.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on legal grant, IDLE->RESP on illegal grant, ACCESS->RESP always, RESP->IDLE always.
REQ-019 In IDLE with any req_i high, SHALL assert gnt_o for exactly one winner that cycle and latch its we/addr/wdata/mem_op and index.
REQ-020 SHALL arbitrate round-robin: single requester wins; on simultaneous requests, the one not granted last wins; priority pointer resets to favour requester 0.
REQ-021 SHALL ignore req_i outside IDLE; gnt_o SHALL be 0 in ACCESS and RESP.
REQ-022 SHALL flag illegal: H/HU with addr[0]=1; W with addr[1:0]!=00; mem_op 011/110/111; addr[31:11]!=0; addr[10:8]=11x; store with addr[10:8]=101 (switch input region).
REQ-023 In ACCESS, SHALL drive lsu_addr_o/lsu_mem_op_o/lsu_st_data_o from latched values and lsu_st_en_o = latched we for exactly this one cycle.
REQ-024 For loads, SHALL capture lsu_ld_data_i at end of ACCESS into the response register.
REQ-025 In RESP, SHALL pulse rvalid_o for the latched index with rdata_o = captured data (load) or 0 (store/error), err_o = illegal flag.
REQ-026 Illegal accesses SHALL never assert lsu_st_en_o nor enter ACCESS.
REQ-027 Outside ACCESS, lsu_st_en_o=0, lsu_addr_o=0, lsu_st_data_o=0, lsu_mem_op_o=010.
REQ-028 Latency: grant cycle N, LSU cycle N+1, rvalid N+2; next grant earliest N+3.
REQ-029 rdata_o and err_o SHALL hold value until next RESP; rvalid_o is the qualifier.

Reset
REQ-030 While rst_ni=1: state IDLE, gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, LSU outputs per REQ-027, pointer favours requester 0.
REQ-031 Reset asserted in ACCESS or RESP SHALL abort: no lsu_st_en_o and no rvalid_o in that cycle or after release.
REQ-032 First grant possible in the cycle after rst_ni deasserts.

Verification
REQ-033 Req0 store W 0x0000_0010 data 0xDEADBEEF -> gnt_o=01 cycle N, lsu_st_en_o=1 cycle N+1 addr 0x10, rvalid_o=01 N+2, err_o=0, rdata_o=0.
REQ-034 Req0 load W 0x10 with lsu_ld_data_i=0xDEADBEEF in ACCESS -> rvalid_o=01 at N+2, rdata_o=0xDEADBEEF.
REQ-035 Both req high continuously, 4 accesses -> grants 01,10,01,10 every 3 cycles.
REQ-036 Req1 load H at 0x0000_0003 -> gnt_o=10, no ACCESS cycle, rvalid_o=10 at N+1, err_o=1; store W to 0x500 -> err_o=1, lsu_st_en_o never 1.
REQ-037 Reset asserted in ACCESS cycle of a store -> lsu_st_en_o=0 that cycle, no rvalid_o, next req0 after release granted with pointer at requester 0.
